acc_bank: RTL and testbench
===========================

ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 Parameter WIDTH, default 24, is the data width of each accumulator and of every data port.
REQ-002 Parameter DEPTH, default 4, is the number of accumulators; legal range is 2..16, and non-powers of 2 are allowed.
REQ-003 Parameter AW, default 2, is the select width; AW SHALL be at least ceil(log2(DEPTH)).
REQ-004 clk  in  1  is the single clock; all state updates on the rising edge.
REQ-005 reset  in  1  is the asynchronous, active-low reset.
REQ-006 write  in  1  loads data_in into acc[sel].
REQ-007 inc  in  1  increments acc[sel] by 1.
REQ-008 clr  in  1  clears acc[sel] to 0.
REQ-009 read_bus  in  1  requests that acc[sel] be driven onto BUS_OUT.
REQ-010 sel  in  AW  is the accumulator index used by write, inc, clr and read_bus.
REQ-011 alu_sel  in  AW  is the accumulator index presented on ALU_IN.
REQ-012 data_in  in  WIDTH  is the load data.
REQ-013 BUS_OUT  out  WIDTH  is the registered bus read data.
REQ-014 bus_valid  out  1  marks BUS_OUT as carrying fresh read data for one cycle.
REQ-015 ALU_IN  out  WIDTH  is the combinational view of acc[alu_sel].
REQ-016 zero  out  1  is registered and is 1 when acc[sel] is 0 after the update of the previous cycle.
REQ-017 carry  out  1  is a registered one-cycle pulse on increment wrap.

Function
REQ-018 Per cycle, at most one update is applied to acc[sel], with priority clr > write > inc; the lower-priority requests are ignored that cycle.
REQ-019 Accumulators not addressed by sel SHALL hold their value.
REQ-020 clr: acc[sel] <= 0 at the next edge.
REQ-021 write: acc[sel] <= data_in at the next edge, with 1-cycle latency.
REQ-022 inc: acc[sel] <= acc[sel]+1 modulo 2^WIDTH.
REQ-023 When an applied inc wraps all-ones to 0, carry SHALL be 1 in the following cycle and 0 otherwise.
REQ-024 read_bus: at the next edge, BUS_OUT <= acc[sel] value before any same-cycle update (read-before-write), and bus_valid <= 1.
REQ-025 Without read_bus, bus_valid <= 0 and BUS_OUT holds its last value.
REQ-026 read_bus held high for N cycles SHALL produce N consecutive valid beats, each reflecting the pre-update value of its own cycle.
REQ-027 ALU_IN SHALL be combinational from the current acc[alu_sel] register; a write becomes visible on ALU_IN in the cycle after the edge.
REQ-028 zero is computed from the post-update value of acc[sel] at each edge, whether or not an operation occurred.
REQ-029 sel >= DEPTH: write, inc and clr are ignored; read_bus returns BUS_OUT=0 with bus_valid=1; zero=1; carry=0.
REQ-030 alu_sel >= DEPTH: ALU_IN=0.
REQ-031 No X SHALL propagate to any output for any in-range or out-of-range select.

Reset
REQ-032 While reset=0, all accumulators, BUS_OUT, bus_valid and carry SHALL be 0 and zero SHALL be 1, asynchronously and without waiting for a clock.
REQ-033 Assertion of reset mid-operation discards any pending update; the first edge after reset deassertion behaves as a normal cycle.

Verification
REQ-034 Load then read: write=1, sel=2, data_in=100 for one cycle, then read_bus=1, sel=2 -> BUS_OUT=100 with bus_valid=1 one cycle later, and ALU_IN=100 when alu_sel=2.
REQ-035 Read-before-write: acc[1]=5; write=1, read_bus=1, sel=1, data_in=9 in the same cycle -> BUS_OUT=5 next cycle, then acc[1]=9 on the following read.
REQ-036 Priority: clr=1, write=1, inc=1, sel=0, data_in=7 -> acc[0]=0 and zero=1; then write=1, inc=1, data_in=7 -> acc[0]=7 (inc ignored).
REQ-037 Wrap: write 24'hFFFFFF to acc[3], then inc -> acc[3]=0, carry=1 for exactly one cycle, zero=1.
REQ-038 Async reset: with all accumulators loaded nonzero and read_bus=1, drive reset=0 between clock edges -> all outputs reach reset values immediately, and ALU_IN=0 for every alu_sel.
REQ-039 Out-of-range select, run with DEPTH=3, AW=2: write sel=3, data_in=55, then read sel=3 -> BUS_OUT=0, bus_valid=1, and accumulators 0..2 are unchanged.

Source files
------------

// File: rtl/acc_bank.sv
// Bank of DEPTH accumulators with prioritised clr/write/inc, a registered
// read-before-write bus port and a combinational ALU view of one entry.
module acc_bank #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             inc,
  input  logic             clr,
  input  logic             read_bus,
  input  logic [AW-1:0]    sel,
  input  logic [AW-1:0]    alu_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] BUS_OUT,
  output logic             bus_valid,
  output logic [WIDTH-1:0] ALU_IN,
  output logic             zero,
  output logic             carry
);

  logic [WIDTH-1:0] acc [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   sum;
  logic             sel_ok;
  logic             wrap;

  assign sel_ok = (32'(sel) < DEPTH);

  // Current value of the selected entry; out-of-range selects read as 0.
  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(sel) == i) cur = acc[i];
    end
  end

  // Post-update value of the selected entry, priority clr > write > inc.
  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    sum  = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
    if (sel_ok) begin
      if (clr) begin
        nxt = '0;
      end else if (write) begin
        nxt = data_in;
      end else if (inc) begin
        nxt  = sum[WIDTH-1:0];
        wrap = sum[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (32'(sel) == i) acc[i] <= nxt;
      end
    end
  end

  // Bus read captures the pre-update value; status flags follow the update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BUS_OUT   <= '0;
      bus_valid <= 1'b0;
      zero      <= 1'b1;
      carry     <= 1'b0;
    end else begin
      if (read_bus) BUS_OUT <= cur;
      bus_valid <= read_bus;
      zero      <= (nxt == '0);
      carry     <= wrap;
    end
  end

  always_comb begin
    ALU_IN = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(alu_sel) == i) ALU_IN = acc[i];
    end
  end

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: directed scenarios plus randomized traffic
// against a behavioural model; a DEPTH=3 instance covers out-of-range selects.
module tb_acc_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        write, inc, clr, read_bus;
  logic [1:0]  sel, alu_sel;
  logic [23:0] data_in;
  logic [23:0] BUS_OUT, ALU_IN;
  logic        bus_valid, zero, carry;

  logic        write3, inc3, clr3, read3;
  logic [1:0]  sel3, alu3;
  logic [23:0] data3;
  logic [23:0] bus3, alu_in3;
  logic        valid3, zero3, carry3;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the default 4-entry bank
  int unsigned m_acc [4];
  logic [23:0] exp_bus;
  logic        exp_valid, exp_zero, exp_carry;

  always #5 clk = ~clk;

  acc_bank u_dut (
    .clk(clk), .reset(reset), .write(write), .inc(inc), .clr(clr),
    .read_bus(read_bus), .sel(sel), .alu_sel(alu_sel), .data_in(data_in),
    .BUS_OUT(BUS_OUT), .bus_valid(bus_valid), .ALU_IN(ALU_IN),
    .zero(zero), .carry(carry)
  );

  acc_bank #(.WIDTH(24), .DEPTH(3), .AW(2)) u_dut3 (
    .clk(clk), .reset(reset), .write(write3), .inc(inc3), .clr(clr3),
    .read_bus(read3), .sel(sel3), .alu_sel(alu3), .data_in(data3),
    .BUS_OUT(bus3), .bus_valid(valid3), .ALU_IN(alu_in3),
    .zero(zero3), .carry(carry3)
  );

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_acc[k] = 0;
    exp_bus   = '0;
    exp_valid = 1'b0;
    exp_zero  = 1'b1;
    exp_carry = 1'b0;
  endtask

  // Drive one cycle on the main instance, advance the model, sample at edge+1.
  task automatic cycle(input logic w, input logic i, input logic c, input logic r,
                       input logic [1:0] s, input logic [1:0] a, input logic [23:0] d);
    write = w; inc = i; clr = c; read_bus = r; sel = s; alu_sel = a; data_in = d;
    exp_valid = r;
    if (r) exp_bus = 24'(m_acc[s]);
    exp_carry = 1'b0;
    if (c) m_acc[s] = 0;
    else if (w) m_acc[s] = 32'(d);
    else if (i) begin
      exp_carry = (m_acc[s] == 32'h00FF_FFFF);
      m_acc[s] = (m_acc[s] + 1) % 32'h0100_0000;
    end
    exp_zero = (m_acc[s] == 0);
    @(posedge clk); #1;
  endtask

  task automatic cycle3(input logic w, input logic i, input logic c, input logic r,
                        input logic [1:0] s, input logic [1:0] a, input logic [23:0] d);
    write3 = w; inc3 = i; clr3 = c; read3 = r; sel3 = s; alu3 = a; data3 = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    checks++; if (BUS_OUT !== 24'd0) begin errors++; $display("FAIL reset_bus: got %h want 0", BUS_OUT); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry); end
    for (int a = 0; a < 4; a++) begin
      alu_sel = 2'(a);
      #1;
      checks++; if (ALU_IN !== 24'd0) begin errors++; $display("FAIL reset_alu[%0d]: got %h want 0", a, ALU_IN); end
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_load_read();
    cycle(1, 0, 0, 0, 2'd2, 2'd2, 24'd100);
    checks++; if (ALU_IN !== 24'd100) begin errors++; $display("FAIL load_alu: got %0d want 100", ALU_IN); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL load_zero: got %b want 0", zero); end
    cycle(0, 0, 0, 1, 2'd2, 2'd2, 24'd0);
    checks++; if (BUS_OUT !== 24'd100) begin errors++; $display("FAIL load_bus: got %0d want 100", BUS_OUT); end
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b want 1", bus_valid); end
  endtask

  task automatic test_read_before_write();
    cycle(1, 0, 0, 0, 2'd1, 2'd1, 24'd5);
    cycle(1, 0, 0, 1, 2'd1, 2'd1, 24'd9);
    checks++; if (BUS_OUT !== 24'd5) begin errors++; $display("FAIL rbw_bus: got %0d want 5", BUS_OUT); end
    checks++; if (ALU_IN !== 24'd9) begin errors++; $display("FAIL rbw_alu: got %0d want 9", ALU_IN); end
    cycle(0, 0, 0, 1, 2'd1, 2'd1, 24'd0);
    checks++; if (BUS_OUT !== 24'd9) begin errors++; $display("FAIL rbw_second_read: got %0d want 9", BUS_OUT); end
  endtask

  task automatic test_priority();
    cycle(1, 0, 0, 0, 2'd0, 2'd0, 24'd3);
    cycle(1, 1, 1, 0, 2'd0, 2'd0, 24'd7);
    checks++; if (ALU_IN !== 24'd0) begin errors++; $display("FAIL prio_clr_acc: got %0d want 0", ALU_IN); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL prio_clr_zero: got %b want 1", zero); end
    cycle(1, 1, 0, 0, 2'd0, 2'd0, 24'd7);
    checks++; if (ALU_IN !== 24'd7) begin errors++; $display("FAIL prio_write_acc: got %0d want 7", ALU_IN); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL prio_write_zero: got %b want 0", zero); end
    cycle(0, 1, 0, 0, 2'd0, 2'd0, 24'd0);
    checks++; if (ALU_IN !== 24'd8) begin errors++; $display("FAIL prio_inc_acc: got %0d want 8", ALU_IN); end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 0, 2'd3, 2'd3, 24'hFFFFFF);
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL wrap_pre_carry: got %b want 0", carry); end
    cycle(0, 1, 0, 0, 2'd3, 2'd3, 24'd0);
    checks++; if (ALU_IN !== 24'd0) begin errors++; $display("FAIL wrap_acc: got %h want 0", ALU_IN); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL wrap_carry: got %b want 1", carry); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL wrap_zero: got %b want 1", zero); end
    cycle(0, 0, 0, 0, 2'd3, 2'd3, 24'd0);
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL wrap_carry_drop: got %b want 0", carry); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL wrap_idle_zero: got %b want 1", zero); end
  endtask

  task automatic test_back_to_back();
    // acc[1] holds 9 here; each beat shows the value before that cycle's inc
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, 1, 2'd1, 2'd1, 24'd0);
      checks++; if (BUS_OUT !== 24'(9 + k) || bus_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_beat%0d: got %0d/%b want %0d/1", k, BUS_OUT, bus_valid, 9 + k);
      end
    end
    cycle(0, 0, 0, 0, 2'd1, 2'd1, 24'd0);
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", bus_valid); end
    checks++; if (BUS_OUT !== 24'd12) begin errors++; $display("FAIL b2b_bus_hold: got %0d want 12", BUS_OUT); end
  endtask

  task automatic test_random();
    logic w, i, c, r;
    logic [23:0] d;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(7, 0) == 0);
      w = ($urandom_range(2, 0) == 0);
      i = ($urandom_range(1, 0) == 0);
      r = ($urandom_range(1, 0) == 0);
      d = ($urandom_range(3, 0) == 0) ? 24'hFFFFFF - 24'($urandom_range(1, 0)) : 24'($urandom);
      cycle(w, i, c, r, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), d);
      checks++; if (BUS_OUT !== exp_bus) begin errors++; $display("FAIL rand_bus@%0d: got %h want %h", n, BUS_OUT, exp_bus); end
      checks++; if (bus_valid !== exp_valid) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", n, bus_valid, exp_valid); end
      checks++; if (zero !== exp_zero) begin errors++; $display("FAIL rand_zero@%0d: got %b want %b", n, zero, exp_zero); end
      checks++; if (carry !== exp_carry) begin errors++; $display("FAIL rand_carry@%0d: got %b want %b", n, carry, exp_carry); end
      checks++; if (ALU_IN !== 24'(m_acc[alu_sel])) begin
        errors++; $display("FAIL rand_alu@%0d: got %h want %h", n, ALU_IN, 24'(m_acc[alu_sel]));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1, 2'(k), 2'(k), 24'(k + 17));
    cycle(0, 0, 0, 1, 2'd0, 2'd0, 24'd0);
    checks++; if (bus_valid !== 1'b1 || ALU_IN !== 24'd17) begin
      errors++; $display("FAIL areset_pre: got %b/%0d want 1/17", bus_valid, ALU_IN);
    end
    // Leave a write pending so the reset has something to discard
    write = 1'b1; data_in = 24'd77;
    #2 reset = 1'b0;
    #1;
    checks++; if (BUS_OUT !== 24'd0) begin errors++; $display("FAIL areset_bus: got %h want 0", BUS_OUT); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", bus_valid); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL areset_zero: got %b want 1", zero); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL areset_carry: got %b want 0", carry); end
    for (int a = 0; a < 4; a++) begin
      alu_sel = 2'(a);
      #1;
      checks++; if (ALU_IN !== 24'd0) begin errors++; $display("FAIL areset_alu[%0d]: got %h want 0", a, ALU_IN); end
    end
    @(posedge clk); #1;
    write = 1'b0; read_bus = 1'b0; alu_sel = 2'd0;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (ALU_IN !== 24'd0) begin errors++; $display("FAIL areset_discard: got %0d want 0", ALU_IN); end
    cycle(1, 0, 0, 0, 2'd2, 2'd2, 24'h123456);
    checks++; if (ALU_IN !== 24'h123456) begin errors++; $display("FAIL areset_first_edge: got %h want 123456", ALU_IN); end
  endtask

  task automatic test_out_of_range();
    logic [23:0] v [3];
    for (int k = 0; k < 3; k++) begin
      v[k] = 24'($urandom_range(32'hFFFFFE, 1));
      cycle3(1, 0, 0, 0, 2'(k), 2'(k), v[k]);
    end
    cycle3(1, 0, 0, 0, 2'd3, 2'd3, 24'd55);
    checks++; if (zero3 !== 1'b1) begin errors++; $display("FAIL oor_write_zero: got %b want 1", zero3); end
    checks++; if (alu_in3 !== 24'd0) begin errors++; $display("FAIL oor_alu: got %h want 0", alu_in3); end
    cycle3(0, 1, 1, 0, 2'd3, 2'd3, 24'd0);
    cycle3(0, 1, 0, 0, 2'd3, 2'd3, 24'd0);
    checks++; if (carry3 !== 1'b0) begin errors++; $display("FAIL oor_inc_carry: got %b want 0", carry3); end
    cycle3(0, 0, 0, 1, 2'd0, 2'd0, 24'd0);
    cycle3(0, 0, 0, 1, 2'd3, 2'd3, 24'd0);
    checks++; if (bus3 !== 24'd0 || valid3 !== 1'b1) begin
      errors++; $display("FAIL oor_read: got %h/%b want 0/1", bus3, valid3);
    end
    checks++; if (zero3 !== 1'b1) begin errors++; $display("FAIL oor_read_zero: got %b want 1", zero3); end
    for (int k = 0; k < 3; k++) begin
      cycle3(0, 0, 0, 1, 2'(k), 2'(k), 24'd0);
      checks++; if (bus3 !== v[k] || alu_in3 !== v[k]) begin
        errors++; $display("FAIL oor_hold[%0d]: got %h/%h want %h", k, bus3, alu_in3, v[k]);
      end
    end
    cycle3(0, 0, 0, 0, 2'd0, 2'd0, 24'd0);
  endtask

  initial begin
    write = 0; inc = 0; clr = 0; read_bus = 0; sel = 0; alu_sel = 0; data_in = 0;
    write3 = 0; inc3 = 0; clr3 = 0; read3 = 0; sel3 = 0; alu3 = 0; data3 = 0;
    model_reset();
    test_reset();
    test_load_read();
    test_read_before_write();
    test_back_to_back();
    test_priority();
    test_wrap();
    test_random();
    test_async_reset();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
